// File: rtl/ctext_serializer.sv
// Streams a 128-bit ciphertext block out as 16 bytes over a valid/ready link,
// with one pending slot so a block can follow another without a bubble.
module ctext_serializer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] ctext0,
    input  logic [31:0] ctext1,
    input  logic [31:0] ctext2,
    input  logic [31:0] ctext3,
    input  logic        out_ready,
    output logic [7:0]  data_out,
    output logic        out_valid,
    output logic        sof,
    output logic        eof,
    output logic        in_ready,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(15);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLK_W-1:0]   shreg_q, shreg_d;
    logic [BLK_W-1:0]   pend_q, pend_d;
    logic               pend_v_q, pend_v_d;
    logic               overflow_q, overflow_d;
    logic [BLK_W-1:0]   blk_in;
    logic               hs;

    // Reorder each word so the shift register always emits from its top byte.
    function automatic logic [31:0] order_word(input logic [31:0] w);
        if (MSB_FIRST) begin
            return w;
        end
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign blk_in = {order_word(ctext0), order_word(ctext1),
                     order_word(ctext2), order_word(ctext3)};

    assign out_valid = (state_q == SEND);
    assign hs        = out_valid && out_ready;
    assign data_out  = out_valid ? shreg_q[BLK_W-1 -: BYTE_W] : 8'h00;
    assign sof       = out_valid && (idx_q == '0);
    assign eof       = out_valid && (idx_q == LAST_IDX);
    assign in_ready  = !pend_v_q;
    assign busy      = out_valid || pend_v_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shreg_q    <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        overflow_d = overflow_q;

        // A full pending slot drops the new block, even if it frees up this cycle.
        if (load && pend_v_q) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = blk_in;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs && (idx_q == LAST_IDX)) begin
                    idx_d = '0;
                    if (pend_v_q) begin
                        shreg_d  = pend_q;
                        pend_v_d = 1'b0;
                    end else if (load) begin
                        shreg_d = blk_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (hs) begin
                        shreg_d = {shreg_q[BLK_W-BYTE_W-1:0], 8'h00};
                        idx_d   = idx_q + IDX_W'(1);
                    end
                    if (load && !pend_v_q) begin
                        pend_d   = blk_in;
                        pend_v_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctext_serializer.sv
// Checks ctext_serializer (both byte orders) against a block-queue model of the stream.
module tb_ctext_serializer;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] ctext0, ctext1, ctext2, ctext3;
    logic        out_ready;

    logic [7:0]  d0, d1;
    logic        v0, v1, sof0, sof1, eof0, eof1, ir0, ir1, busy0, busy1, ovf0, ovf1;

    int tests = 0;
    int fails = 0;

    // Model: blocks accepted but not fully sent, position in the head block, sticky drop flag.
    logic [127:0] mq[$];
    int           mpos = 0;
    bit           movf = 0;

    logic [7:0] log0[$];
    logic [7:0] log1[$];

    logic [7:0] lit_msb[16] = '{8'h39, 8'h25, 8'h84, 8'h1d, 8'h02, 8'hdc, 8'h09, 8'hfb,
                                8'hdc, 8'h11, 8'h85, 8'h97, 8'h19, 8'h6a, 8'h0b, 8'h32};
    logic [7:0] lit_lsb[16] = '{8'h1d, 8'h84, 8'h25, 8'h39, 8'hfb, 8'h09, 8'hdc, 8'h02,
                                8'h97, 8'h85, 8'h11, 8'hdc, 8'h32, 8'h0b, 8'h6a, 8'h19};

    ctext_serializer #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .load(load),
        .ctext0(ctext0), .ctext1(ctext1), .ctext2(ctext2), .ctext3(ctext3),
        .out_ready(out_ready), .data_out(d0), .out_valid(v0), .sof(sof0), .eof(eof0),
        .in_ready(ir0), .busy(busy0), .overflow(ovf0));

    ctext_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load(load),
        .ctext0(ctext0), .ctext1(ctext1), .ctext2(ctext2), .ctext3(ctext3),
        .out_ready(out_ready), .data_out(d1), .out_valid(v1), .sof(sof1), .eof(eof1),
        .in_ready(ir1), .busy(busy1), .overflow(ovf1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mbyte(input logic [127:0] blk, input int k, input bit msb);
        logic [31:0] w;
        int j;
        w = blk[127 - 32*(k/4) -: 32];
        j = k % 4;
        if (msb) return 8'(w >> (8*(3-j)));
        return 8'(w >> (8*j));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit accept;
        if (rst) begin
            mq.delete();
            mpos = 0;
            movf = 0;
            return;
        end
        accept = load && (mq.size() < 2);
        if (load && !accept) movf = 1;
        if ((mq.size() > 0) && out_ready) begin
            if (mpos == 15) begin
                mq.delete(0);
                mpos = 0;
            end else begin
                mpos++;
            end
        end
        if (accept) mq.push_back({ctext0, ctext1, ctext2, ctext3});
    endtask

    task automatic check_outputs();
        bit       ev;
        logic [7:0] eb0, eb1;
        ev  = (mq.size() > 0);
        eb0 = ev ? mbyte(mq[0], mpos, 1'b1) : 8'h00;
        eb1 = ev ? mbyte(mq[0], mpos, 1'b0) : 8'h00;
        chk("msb.out_valid", 32'(v0), 32'(ev));
        chk("msb.data_out",  32'(d0), 32'(eb0));
        chk("msb.sof",       32'(sof0), 32'(ev && mpos == 0));
        chk("msb.eof",       32'(eof0), 32'(ev && mpos == 15));
        chk("msb.in_ready",  32'(ir0), 32'(mq.size() < 2));
        chk("msb.busy",      32'(busy0), 32'(ev));
        chk("msb.overflow",  32'(ovf0), 32'(movf));
        chk("lsb.out_valid", 32'(v1), 32'(ev));
        chk("lsb.data_out",  32'(d1), 32'(eb1));
        chk("lsb.sof",       32'(sof1), 32'(ev && mpos == 0));
        chk("lsb.eof",       32'(eof1), 32'(ev && mpos == 15));
        chk("lsb.in_ready",  32'(ir1), 32'(mq.size() < 2));
        chk("lsb.busy",      32'(busy1), 32'(ev));
        chk("lsb.overflow",  32'(ovf1), 32'(movf));
    endtask

    // One clock: log handshakes, advance the model at the edge, compare on the falling edge.
    task automatic cycle();
        if (v0 && out_ready) log0.push_back(d0);
        if (v1 && out_ready) log1.push_back(d1);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        #1;
    endtask

    task automatic set_block(input logic [31:0] a, b, c, d);
        ctext0 = a; ctext1 = b; ctext2 = c; ctext3 = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    int vcount;

    initial begin
        rst = 1'b1; load = 1'b0; out_ready = 1'b1;
        set_block(32'h0, 32'h0, 32'h0, 32'h0);
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset.in_ready", 32'(ir0), 32'd1);
        chk("reset.out_valid", 32'(v0), 32'd0);
        chk("reset.data_out", 32'(d0), 32'd0);

        // Basic stream, both byte orders
        log0.delete(); log1.delete();
        set_block(32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32);
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("basic.first_valid", 32'(v0), 32'd1);
        chk("basic.first_sof", 32'(sof0), 32'd1);
        chk("basic.first_byte", 32'(d0), 32'h39);
        for (int i = 0; i < 20; i++) cycle();
        chk("basic.count", 32'(log0.size()), 32'd16);
        for (int i = 0; i < 16 && i < log0.size(); i++) chk($sformatf("basic.msb[%0d]", i), 32'(log0[i]), 32'(lit_msb[i]));
        for (int i = 0; i < 16 && i < log1.size(); i++) chk($sformatf("basic.lsb[%0d]", i), 32'(log1[i]), 32'(lit_lsb[i]));
        chk("basic.idle_after", 32'(v0), 32'd0);

        // Backpressure while byte 4 is presented
        log0.delete(); log1.delete();
        load = 1'b1;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp.hold_byte", 32'(d0), 32'h02);
            chk("bp.hold_valid", 32'(v0), 32'd1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        chk("bp.count", 32'(log0.size()), 32'd16);
        for (int i = 0; i < 16 && i < log0.size(); i++) chk($sformatf("bp.msb[%0d]", i), 32'(log0[i]), 32'(lit_msb[i]));

        // Back-to-back: B loaded while A's byte 3 is on the bus
        log0.delete(); log1.delete();
        vcount = 0;
        load = 1'b1;
        cycle();
        load = 1'b0;
        vcount += int'(v0);
        for (int i = 0; i < 3; i++) begin cycle(); vcount += int'(v0); end
        set_block(32'ha0a1a2a3, 32'hb0b1b2b3, 32'hc0c1c2c3, 32'hd0d1d2d3);
        load = 1'b1;
        cycle();
        load = 1'b0;
        vcount += int'(v0);
        chk("b2b.in_ready_low", 32'(ir0), 32'd0);
        for (int i = 0; i < 40; i++) begin cycle(); vcount += int'(v0); end
        chk("b2b.valid_cycles", 32'(vcount), 32'd32);
        chk("b2b.count", 32'(log0.size()), 32'd32);
        if (log0.size() > 16) chk("b2b.B0", 32'(log0[16]), 32'ha0);
        if (log0.size() > 15) chk("b2b.A15", 32'(log0[15]), 32'h32);

        // Overflow: third load within one block is dropped
        log0.delete(); log1.delete();
        set_block(32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111);
        load = 1'b1; cycle();
        set_block(32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222);
        cycle();
        set_block(32'h33333333, 32'h33333333, 32'h33333333, 32'h33333333);
        cycle();
        load = 1'b0;
        chk("ovf.set", 32'(ovf0), 32'd1);
        for (int i = 0; i < 40; i++) cycle();
        chk("ovf.count", 32'(log0.size()), 32'd32);
        if (log0.size() == 32) chk("ovf.last_is_B", 32'(log0[31]), 32'h22);
        chk("ovf.sticky", 32'(ovf0), 32'd1);
        do_reset();
        chk("ovf.cleared", 32'(ovf0), 32'd0);

        // Reset mid-block at byte 7
        set_block(32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32);
        load = 1'b1; cycle(); load = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        chk("rstmid.byte7", 32'(d0), 32'hfb);
        do_reset();
        chk("rstmid.valid", 32'(v0), 32'd0);
        chk("rstmid.busy", 32'(busy0), 32'd0);
        set_block(32'h5a5b5c5d, 32'h0, 32'h0, 32'h0);
        load = 1'b1; cycle(); load = 1'b0;
        chk("rstmid.sof", 32'(sof0), 32'd1);
        chk("rstmid.byte0", 32'(d0), 32'h5a);
        for (int i = 0; i < 20; i++) cycle();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            rst       = ($urandom_range(0, 599) == 0);
            load      = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_block($urandom, $urandom, $urandom, $urandom);
            cycle();
        end
        rst = 1'b0; load = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
